// File: rtl/multi_cycle_alu.sv
// Purpose : 32-bit ALU; single-cycle ops plus iterative one-bit-per-cycle shifts.
// Latency : 1 cycle for non-shift ops and zero shifts, n+1 cycles for a shift by n.
// Backpr. : start is taken only in IDLE/DONE; start during SHIFT is dropped, not queued.
module multi_cycle_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  Operation,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic        done,
   output logic [31:0] ALUResult,
   output logic        Zero,
   output logic        illegal_op
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  op_q;        // captured op, steers the shift direction
   logic [31:0] sh_q;        // working shift register, never visible on ALUResult
   logic [4:0]  cnt;         // remaining shift steps
   logic [31:0] result_q;
   logic        zero_q;
   logic        illegal_q;

   logic        accept;
   logic        is_shift;
   logic        start_shift;
   logic [31:0] comb_res;
   logic        comb_ill;
   logic [31:0] sh_step;

   // Request acceptance: only when not iterating a shift.
   always_comb begin
      accept      = start && ((state == IDLE) || (state == DONE));
      is_shift    = (Operation == OP_SRL) || (Operation == OP_SLL) || (Operation == OP_SRA);
      start_shift = accept && is_shift && (SrcB[4:0] != 5'd0);
   end

   // Single-cycle result from the live operands; a zero-length shift passes SrcA through.
   always_comb begin
      comb_res = 32'd0;
      comb_ill = 1'b0;
      case (Operation)
         OP_ADD:  comb_res = SrcA + SrcB;
         OP_SUB:  comb_res = SrcA - SrcB;
         OP_XOR:  comb_res = SrcA ^ SrcB;
         OP_OR:   comb_res = SrcA | SrcB;
         OP_AND:  comb_res = SrcA & SrcB;
         OP_SRL,
         OP_SLL,
         OP_SRA:  comb_res = SrcA;
         OP_SLT:  comb_res = {31'd0, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: comb_res = {31'd0, (SrcA < SrcB)};
         OP_BEQ:  comb_res = SrcA - SrcB;
         default: comb_ill = 1'b1;
      endcase
   end

   // One-bit shift step according to the captured op.
   always_comb begin
      sh_step = sh_q;
      case (op_q)
         OP_SLL:  sh_step = {sh_q[30:0], 1'b0};
         OP_SRL:  sh_step = {1'b0, sh_q[31:1]};
         default: sh_step = {sh_q[31], sh_q[31:1]};
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status decode.
   always_comb begin
      state_nxt = state;
      busy      = (state == SHIFT);
      done      = (state == DONE);
      case (state)
         IDLE,
         DONE: begin
            if (start) state_nxt = start_shift ? SHIFT : DONE;
            else       state_nxt = IDLE;
         end
         SHIFT: begin
            if (cnt == 5'd1) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, shift iteration, and result/flag registers updated together.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= 4'd0;
         sh_q      <= 32'd0;
         cnt       <= 5'd0;
         result_q  <= 32'd0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         if (accept) begin
            op_q <= Operation;
            sh_q <= SrcA;
            if (start_shift) begin
               cnt <= SrcB[4:0];
            end else begin
               cnt       <= 5'd0;
               result_q  <= comb_res;
               zero_q    <= (comb_res == 32'd0);
               illegal_q <= comb_ill;
            end
         end else if (state == SHIFT) begin
            sh_q <= sh_step;
            cnt  <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               result_q <= sh_step;
               zero_q   <= (sh_step == 32'd0);
            end
         end
      end
   end

   assign ALUResult  = result_q;
   assign Zero       = zero_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Purpose : directed table-driven bench for multi_cycle_alu plus multi-cycle corner sequences.
// Latency : measured per request in cycles from the accepting edge to the done cycle.
// Backpr. : start pulses during SHIFT are driven and must be ignored.
module tb_multi_cycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        illegal_op;

   int tests = 0;
   int fails = 0;

   multi_cycle_alu dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .Operation  (Operation),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .busy       (busy),
      .done       (done),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          lat;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request, wait (bounded) for done, then check result, flags, latency and hold.
   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int busy_n;
      @(negedge clk);
      Operation = v.op; SrcA = v.a; SrcB = v.b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
      lat = 1; busy_n = 0;
      while (!done && lat < 100) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d busy cycles", idx), 32'(busy_n), 32'(v.lat - 1));
      check($sformatf("v%0d result", idx), ALUResult, v.res);
      check($sformatf("v%0d zero", idx), {31'd0, Zero}, {31'd0, v.zero});
      check($sformatf("v%0d illegal", idx), {31'd0, illegal_op}, {31'd0, v.ill});
      @(posedge clk); #1;
      check($sformatf("v%0d done after", idx), {31'd0, done}, 32'd0);
      check($sformatf("v%0d illegal after", idx), {31'd0, illegal_op}, 32'd0);
      check($sformatf("v%0d result hold", idx), ALUResult, v.res);
   endtask

   initial begin
      int lat;
      int dcount;

      //          op     A             B             result        Z     ill   lat
      vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'hA, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[2]  = '{4'hA, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1};
      vecs[3]  = '{4'h1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
      vecs[4]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'h3, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0, 1};
      vecs[6]  = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
      vecs[7]  = '{4'h6, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1};
      vecs[8]  = '{4'h9, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'h8, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[10] = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
      vecs[11] = '{4'h5, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
      vecs[12] = '{4'h6, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32};
      vecs[13] = '{4'h7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
      vecs[14] = '{4'h7, 32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 1'b0, 3};
      vecs[15] = '{4'h6, 32'h00000003, 32'h00000025, 32'h00000060, 1'b0, 1'b0, 6};
      vecs[16] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 1};
      vecs[17] = '{4'hB, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b1, 1};
      vecs[18] = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[19] = '{4'h5, 32'h0000000F, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 5};

      // Reset state.
      reset = 1'b1; start = 1'b0; Operation = 4'h0; SrcA = 32'd0; SrcB = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset illegal", {31'd0, illegal_op}, 32'd0);
      check("reset result", ALUResult, 32'd0);
      check("reset zero", {31'd0, Zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

      // SRA by 31 with start pulses while busy; ALUResult must keep the previous result.
      @(negedge clk);
      Operation = 4'h7; SrcA = 32'h80000000; SrcB = 32'd31; start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!done && lat < 100) begin
         check($sformatf("sra busy c%0d", lat), {31'd0, busy}, 32'd1);
         if (lat == 10) check("sra no partial", ALUResult, vecs[NVEC-1].res);
         if (lat <= 20) begin
            start = 1'b1; Operation = 4'h0; SrcA = 32'd1; SrcB = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("sra latency", 32'(lat), 32'd32);
      check("sra result", ALUResult, 32'hFFFFFFFF);
      check("sra zero", {31'd0, Zero}, 32'd0);
      @(posedge clk); #1;
      check("sra no extra done", {31'd0, done}, 32'd0);

      // Back-to-back: XOR, OR, then illegal with start held high.
      @(negedge clk);
      Operation = 4'h2; SrcA = 32'hF0F0F0F0; SrcB = 32'hFF00FF00; start = 1'b1;
      @(posedge clk); #1;
      check("b2b xor done", {31'd0, done}, 32'd1);
      check("b2b xor result", ALUResult, 32'h0FF00FF0);
      Operation = 4'h3; SrcA = 32'h0000F000; SrcB = 32'h0000000F;
      @(posedge clk); #1;
      check("b2b or done", {31'd0, done}, 32'd1);
      check("b2b or result", ALUResult, 32'h0000F00F);
      check("b2b or illegal", {31'd0, illegal_op}, 32'd0);
      Operation = 4'hF;
      @(posedge clk); #1;
      check("b2b ill done", {31'd0, done}, 32'd1);
      check("b2b ill result", ALUResult, 32'd0);
      check("b2b ill zero", {31'd0, Zero}, 32'd1);
      check("b2b ill flag", {31'd0, illegal_op}, 32'd1);
      start = 1'b0;
      @(posedge clk); #1;
      check("b2b idle done", {31'd0, done}, 32'd0);
      check("b2b idle illegal", {31'd0, illegal_op}, 32'd0);

      // Reset mid-shift, with a competing start on the reset edge.
      @(negedge clk);
      Operation = 4'h6; SrcA = 32'h00000001; SrcB = 32'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst pre busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1; start = 1'b1; Operation = 4'h0; SrcA = 32'd1; SrcB = 32'd1;
      @(posedge clk); #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst result", ALUResult, 32'd0);
      check("rst zero", {31'd0, Zero}, 32'd0);
      check("rst illegal", {31'd0, illegal_op}, 32'd0);
      reset = 1'b0; start = 1'b0;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) dcount++;
      end
      check("rst no later done", 32'(dcount), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE or DONE.
- Operation  in  4  operation code from the ALU controller.
- SrcA  in  32  first operand.
- SrcB  in  32  second operand; SrcB[4:0] is the shift amount.
- busy  out  1  high while a shift is iterating.
- done  out  1  one-cycle pulse when the result is valid.
- ALUResult  out  32  registered result.
- Zero  out  1  registered flag, high when ALUResult == 0.
- illegal_op  out  1  high with done when Operation is undefined.

REQ-002 Operation encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND.
- 0101 SRL, 0110 SLL, 0111 SRA.
- 1000 SLT (signed), 1001 SLTU (unsigned).
- 1010 BEQ: result is SrcA-SrcB, so Zero high means equal.
- All other codes are illegal.

Function
REQ-003 The FSM SHALL have three states, IDLE, SHIFT and DONE. Outputs SHALL decode as:
- busy = (state == SHIFT).
- done = (state == DONE).

REQ-004 In IDLE or DONE with start=1 at edge T, the block SHALL capture Operation, SrcA and SrcB. Input changes after T are ignored until the next accept.

REQ-005 For any non-shift op, the block SHALL go to DONE at T+1, with ALUResult, Zero and illegal_op valid in that cycle.

REQ-006 For shift ops with shamt=SrcB[4:0]:
- shamt=0: the block SHALL go to DONE at T+1 with ALUResult=SrcA.
- shamt=n>0: the block SHALL enter SHIFT at T+1, shift one bit per cycle with a counter loaded with n and decremented each cycle, and enter DONE at T+n+1.
- Total latency SHALL be n+1 cycles.

REQ-007 Shift fill rules SHALL be:
- SLL fills with 0.
- SRL fills with 0.
- SRA replicates bit 31.

REQ-008 Arithmetic SHALL be 32-bit modulo 2^32 with no carry or overflow outputs. SLT and SLTU SHALL return 32'd1 or 32'd0.

REQ-009 An illegal Operation SHALL produce ALUResult=0, Zero=1 and illegal_op=1 in the DONE cycle. illegal_op SHALL be 0 outside DONE.

REQ-010 ALUResult and Zero SHALL hold their last values until the next DONE cycle updates them. During SHIFT, ALUResult SHALL NOT show partial shift values.

REQ-011 In DONE, the next state SHALL be:
- IDLE if start=0.
- Accept and proceed per REQ-005 or REQ-006 if start=1, giving back-to-back done pulses for single-cycle ops.

REQ-012 start=1 while in SHIFT SHALL be ignored: no capture, no queuing.

REQ-013 Zero SHALL be registered in the same edge as ALUResult and SHALL never be derived combinationally from a stale result.

Reset
REQ-014 reset=1 at any edge, including mid-SHIFT or in DONE, SHALL force:
- state=IDLE, counter=0.
- busy=0, done=0, illegal_op=0.
- ALUResult=0, Zero=0.

REQ-015 reset SHALL take priority over start in the same cycle. Any shift in progress SHALL be discarded with no done pulse.

REQ-016 Outputs SHALL be defined from the first edge with reset=1; there SHALL be no asynchronous behaviour.

Verification
REQ-017 ADD: Operation=0000, A=0x7FFFFFFF, B=1, start at T -> done at T+1, ALUResult=0x80000000, Zero=0.

REQ-018 BEQ: Operation=1010, A=B=0x1234 -> done at T+1, ALUResult=0, Zero=1. Then A=5, B=3 -> ALUResult=2, Zero=0.

REQ-019 SRA: Operation=0111, A=0x80000000, B=31 -> busy for cycles T+1..T+31, done at T+32, ALUResult=0xFFFFFFFF. Start pulses during busy are ignored.

REQ-020 Shift by zero and SLTU: SLL with B=0 -> done at T+1, ALUResult=A. Then SLTU with A=1, B=0xFFFFFFFF -> 1, and SLT on the same operands -> 0.

REQ-021 Back-to-back and illegal: start held high with XOR then OR -> done high two consecutive cycles with correct results. Operation=1111 -> ALUResult=0, Zero=1, illegal_op=1 for one cycle.

REQ-022 Reset mid-shift: SLL with B=20, reset at T+5 -> next cycle busy=0, done=0, ALUResult=0, Zero=0, state IDLE, and no later done pulse.
